nts_tx_dispatch: RTL

- Sits directly downstream of the NTS engine Tx double-buffer.
- Pops completed response packets word-by-word over the buffer's dispatch FIFO interface and presents them as a 64-bit valid/ready frame stream to the MAC Tx path, with per-byte keep and end-of-frame marking.
- Releases the buffer half once the frame has fully left, and enforces an inter-frame gap.
- Guards against runaway or empty packets.

---
 rtl/nts_tx_pkg.sv | 28 ++
 rtl/nts_tx_skid.sv | 46 ++++
 rtl/nts_tx_dispatch.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/nts_tx_pkg.sv
// Shared types and helpers for the NTS engine Tx dispatch path.
package nts_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_FETCH   = 2'd1,
      ST_RELEASE = 2'd2,
      ST_GAP     = 2'd3
   } state_t;

   localparam int SKID_DEPTH = 2;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        error;
   } skid_word_t;

   // Byte 0 lives in the top lane, so N valid bytes light the top N keep bits.
   function automatic logic [7:0] bytes_to_keep(input logic [3:0] i_bytes);
      logic [7:0] w_keep;
      if ((i_bytes == 4'd0) || (i_bytes >= 4'd8)) w_keep = 8'hFF;
      else                                        w_keep = ~(8'hFF >> i_bytes);
      return w_keep;
   endfunction

endpackage

// File: rtl/nts_tx_skid.sv
// Two-entry register FIFO between the Tx buffer read port and the MAC stream.
module nts_tx_skid
   import nts_tx_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_areset_n,
   input  logic       i_push_valid,
   input  skid_word_t i_push_word,
   input  logic       i_pop_ready,
   output logic       o_head_valid,
   output skid_word_t o_head_word,
   output logic [1:0] o_occupancy
);

   skid_word_t r_mem [SKID_DEPTH];
   logic       r_wr_ptr;
   logic       r_rd_ptr;
   logic [1:0] r_count;
   logic       w_push;
   logic       w_pop;

   assign w_pop  = (r_count != 2'd0) && i_pop_ready;
   assign w_push = i_push_valid && ((r_count != 2'd2) || w_pop);

   // Payload storage carries no reset; validity is tracked by r_count.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_word;
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) r_wr_ptr <= ~r_wr_ptr;
         if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign o_head_valid = (r_count != 2'd0);
   assign o_head_word  = r_mem[r_rd_ptr];
   assign o_occupancy  = r_count;

endmodule

// File: rtl/nts_tx_dispatch.sv
// Drains completed packets from the NTS Tx double-buffer onto the 64-bit MAC stream.
module nts_tx_dispatch
   import nts_tx_pkg::*;
#(
   parameter int IFG_CYCLES = 2,
   parameter int MAX_WORDS  = 256,
   parameter int CNT_WIDTH  = 32
)(
   input  logic                 i_clk,
   input  logic                 i_areset_n,
   input  logic                 i_tx_packet_available,
   input  logic                 i_tx_fifo_empty,
   output logic                 o_tx_fifo_rd_en,
   input  logic [63:0]          i_tx_fifo_rd_data,
   input  logic [3:0]           i_tx_bytes_last_word,
   output logic                 o_tx_packet_read,
   output logic                 o_mac_valid,
   input  logic                 i_mac_ready,
   output logic [63:0]          o_mac_data,
   output logic [7:0]           o_mac_keep,
   output logic                 o_mac_last,
   output logic                 o_mac_error,
   output logic                 o_busy,
   output logic                 o_error,
   output logic [CNT_WIDTH-1:0] o_frames_sent,
   output logic [CNT_WIDTH-1:0] o_frames_dropped
);

   localparam int              WC_W    = $clog2(MAX_WORDS + 1);
   localparam int              GAP_LEN = (IFG_CYCLES < 1) ? 1 : IFG_CYCLES;
   localparam int              GC_W    = $clog2(GAP_LEN + 1);
   localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MAX_WORDS);
   localparam logic [GC_W-1:0] GC_LAST = GC_W'(GAP_LEN - 1);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_rd_vld_p1;
   logic                 r_last_seen;
   logic                 r_abort;
   logic                 r_frame_err;
   logic                 r_error;
   logic [WC_W-1:0]      r_word_cnt;
   logic [GC_W-1:0]      r_gap_cnt;
   logic [CNT_WIDTH-1:0] r_frames_sent;
   logic [CNT_WIDTH-1:0] r_frames_dropped;

   logic                 w_head_vld;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_rd_en;
   logic                 w_cnt_max;
   logic                 w_zero_push;
   logic                 w_abort_now;
   logic                 w_empty_pkt;
   logic [1:0]           w_occ;
   logic [1:0]           w_credit;
   skid_word_t           w_push_word;
   skid_word_t           w_head_word;

   // Credit counts the word leaving this cycle so reads can stream at full rate.
   assign w_pop     = w_head_vld && i_mac_ready;
   assign w_credit  = w_occ - {1'b0, w_pop} + {1'b0, r_rd_vld_p1};
   assign w_cnt_max = (r_word_cnt == WC_MAX);
   assign w_rd_en   = (r_state == ST_FETCH) && !i_tx_fifo_empty && !r_last_seen &&
                      !r_abort && (w_credit < 2'd2) && (r_word_cnt < WC_MAX);

   assign w_zero_push = (r_state == ST_FETCH) && w_cnt_max && !r_last_seen && !r_abort &&
                        !r_rd_vld_p1 && (w_occ < 2'd2);
   assign w_abort_now = (r_rd_vld_p1 && !i_tx_fifo_empty && w_cnt_max) || w_zero_push;
   assign w_push      = r_rd_vld_p1 || w_zero_push;

   always_comb begin
      w_push_word = '0;
      if (r_rd_vld_p1) begin
         w_push_word.data  = i_tx_fifo_rd_data;
         w_push_word.keep  = i_tx_fifo_empty ? bytes_to_keep(i_tx_bytes_last_word) : 8'hFF;
         w_push_word.last  = i_tx_fifo_empty || w_abort_now;
         w_push_word.error = w_abort_now;
      end else if (w_zero_push) begin
         w_push_word.keep  = 8'hFF;
         w_push_word.last  = 1'b1;
         w_push_word.error = 1'b1;
      end
   end

   nts_tx_skid u_skid (
      .i_clk        (i_clk),
      .i_areset_n   (i_areset_n),
      .i_push_valid (w_push),
      .i_push_word  (w_push_word),
      .i_pop_ready  (i_mac_ready),
      .o_head_valid (w_head_vld),
      .o_head_word  (w_head_word),
      .o_occupancy  (w_occ)
   );

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) r_state <= ST_IDLE;
      else             r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt      = r_state;
      o_tx_packet_read = 1'b0;
      w_empty_pkt      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_tx_packet_available) begin
               if (i_tx_fifo_empty) begin
                  w_state_nxt = ST_RELEASE;
                  w_empty_pkt = 1'b1;
               end else begin
                  w_state_nxt = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            if ((r_last_seen || r_abort) && !w_head_vld && !r_rd_vld_p1) w_state_nxt = ST_RELEASE;
         end
         ST_RELEASE: begin
            o_tx_packet_read = 1'b1;
            w_state_nxt      = ST_GAP;
         end
         ST_GAP: begin
            if (r_gap_cnt == GC_LAST) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_areset_n) begin
      if (!i_areset_n) begin
         r_rd_vld_p1      <= 1'b0;
         r_last_seen      <= 1'b0;
         r_abort          <= 1'b0;
         r_frame_err      <= 1'b0;
         r_error          <= 1'b0;
         r_word_cnt       <= '0;
         r_gap_cnt        <= '0;
         r_frames_sent    <= '0;
         r_frames_dropped <= '0;
      end else begin
         r_rd_vld_p1 <= w_rd_en;
         if (r_state == ST_IDLE) begin
            r_word_cnt  <= '0;
            r_last_seen <= 1'b0;
            r_abort     <= 1'b0;
            r_frame_err <= 1'b0;
         end
         if (w_rd_en) r_word_cnt <= r_word_cnt + WC_W'(1);
         if (r_rd_vld_p1 && i_tx_fifo_empty) r_last_seen <= 1'b1;
         if (w_abort_now) r_abort <= 1'b1;
         if (w_abort_now || w_empty_pkt) begin
            r_frame_err      <= 1'b1;
            r_error          <= 1'b1;
            r_frames_dropped <= r_frames_dropped + CNT_WIDTH'(1);
         end
         if (r_state == ST_RELEASE) begin
            r_gap_cnt <= '0;
            if (!r_frame_err) r_frames_sent <= r_frames_sent + CNT_WIDTH'(1);
         end
         if (r_state == ST_GAP) r_gap_cnt <= r_gap_cnt + GC_W'(1);
      end
   end

   // Payload lanes are forced to zero whenever no word is being offered.
   assign o_tx_fifo_rd_en  = w_rd_en;
   assign o_mac_valid      = w_head_vld;
   assign o_mac_data       = w_head_vld ? w_head_word.data : 64'd0;
   assign o_mac_keep       = w_head_vld ? w_head_word.keep : 8'd0;
   assign o_mac_last       = w_head_vld && w_head_word.last;
   assign o_mac_error      = w_head_vld && w_head_word.error;
   assign o_busy           = (r_state != ST_IDLE);
   assign o_error          = r_error;
   assign o_frames_sent    = r_frames_sent;
   assign o_frames_dropped = r_frames_dropped;

endmodule
